// File: rtl/alu_simd_pkg.sv
// rtl/alu_simd_pkg.sv - shared SIMD ALU mode constants, segment layout and stage state type
package alu_simd_pkg;

  localparam logic [1:0] MODE_27X18   = 2'b00;
  localparam logic [1:0] MODE_SUM_9X9 = 2'b01;
  localparam logic [1:0] MODE_SUM_4X4 = 2'b10;
  localparam logic [1:0] MODE_SUM_2X2 = 2'b11;

  localparam int NUM_SEG = 8;
  // Bit widths of the ALU segments, seg0 first; they sum to the 45-bit datapath.
  localparam int SEG_WIDTH [NUM_SEG] = '{13, 4, 6, 4, 4, 4, 6, 4};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_HOLD
  } state_t;

  // A segment has carried if either of its two carry-out bits is set.
  function automatic logic [NUM_SEG-1:0] seg_carry_or(input logic [2*NUM_SEG-1:0] carry);
    logic [NUM_SEG-1:0] r;
    for (int i = 0; i < NUM_SEG; i++) begin
      r[i] = carry[2*i] | carry[2*i+1];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_simd_lane_flags.sv
// rtl/alu_simd_lane_flags.sv - maps per-segment sticky carries onto per-lane flags for a SIMD mode
module alu_simd_lane_flags
  import alu_simd_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [7:0] seg_flag,
  output logic [7:0] lane_flag
);

  // Each lane reports the flag of its most significant segment.
  always_comb begin
    lane_flag = '0;
    case (mode)
      MODE_27X18:   lane_flag[0]   = seg_flag[7];
      MODE_SUM_9X9: lane_flag[1:0] = {seg_flag[7], seg_flag[3]};
      MODE_SUM_4X4: lane_flag[3:0] = {seg_flag[7], seg_flag[5], seg_flag[3], seg_flag[1]};
      default:      lane_flag      = seg_flag;
    endcase
  end

endmodule

// File: rtl/alu_simd_accumulator_stage.sv
// rtl/alu_simd_accumulator_stage.sv - multi-beat accumulation stage with ALU feedback and result handshake
module alu_simd_accumulator_stage
  import alu_simd_pkg::*;
#(
  parameter int WIDTH = 45,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       USE_SIMD,
  input  logic [LEN_W-1:0] acc_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] S,
  input  logic [15:0]      simd_carry_out,
  output logic [WIDTH-1:0] W_fb,
  output logic [15:0]      simd_carry_fb,
  output logic [WIDTH-1:0] P,
  output logic [7:0]       lane_flag,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc_q;
  logic [15:0]      carry_q;
  logic [7:0]       seg_flag;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       mode_q;

  logic             accept;
  logic             first_beat;
  logic             last_beat;
  logic [LEN_W-1:0] len_first;
  logic [7:0]       seg_next;
  logic [1:0]       mode_sel;
  logic [7:0]       lane_next;

  assign accept     = in_valid && in_ready;
  assign first_beat = (state == ST_IDLE);
  assign len_first  = (acc_len == '0) ? LEN_W'(1) : acc_len;
  assign seg_next   = first_beat ? seg_carry_or(simd_carry_out)
                                 : (seg_flag | seg_carry_or(simd_carry_out));
  // The first beat uses the live mode because the latched copy is not yet written.
  assign mode_sel   = first_beat ? USE_SIMD : mode_q;
  // Compare one bit wider so cnt+1 cannot wrap at the maximum length.
  assign last_beat  = first_beat ? (len_first == LEN_W'(1))
                                 : (({1'b0, cnt} + (LEN_W+1)'(1)) == {1'b0, len_q});

  alu_simd_lane_flags u_lane_flags (
    .mode      (mode_sel),
    .seg_flag  (seg_next),
    .lane_flag (lane_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b1;
    out_valid     = 1'b0;
    W_fb          = '0;
    simd_carry_fb = '0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = last_beat ? ST_HOLD : ST_ACC;
      end
      ST_ACC: begin
        W_fb          = acc_q;
        simd_carry_fb = carry_q;
        if (accept && last_beat) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      carry_q   <= '0;
      seg_flag  <= '0;
      cnt       <= '0;
      len_q     <= '0;
      mode_q    <= '0;
      P         <= '0;
      lane_flag <= '0;
    end else if (accept) begin
      acc_q    <= S;
      carry_q  <= simd_carry_out;
      seg_flag <= seg_next;
      if (first_beat) begin
        mode_q <= USE_SIMD;
        len_q  <= len_first;
        cnt    <= LEN_W'(1);
      end else begin
        cnt <= cnt + LEN_W'(1);
      end
      if (last_beat) begin
        P         <= S;
        lane_flag <= lane_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_simd_accumulator_stage.sv
// tb/tb_alu_simd_accumulator_stage.sv - randomized and directed self-checking bench for the accumulator stage
module tb_alu_simd_accumulator_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  USE_SIMD;
  logic [7:0]  acc_len;
  logic        in_valid;
  logic        in_ready;
  logic [44:0] S;
  logic [15:0] simd_carry_out;
  logic [44:0] W_fb;
  logic [15:0] simd_carry_fb;
  logic [44:0] P;
  logic [7:0]  lane_flag;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  alu_simd_accumulator_stage #(.WIDTH(45), .LEN_W(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .USE_SIMD       (USE_SIMD),
    .acc_len        (acc_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .S              (S),
    .simd_carry_out (simd_carry_out),
    .W_fb           (W_fb),
    .simd_carry_fb  (simd_carry_fb),
    .P              (P),
    .lane_flag      (lane_flag),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats collected, flags ORed, lanes picked from the top segment.
  logic        m_busy, m_hold;
  int          m_n, m_len;
  logic [1:0]  m_mode;
  logic [44:0] m_s, m_p;
  logic [15:0] m_c;
  logic [7:0]  m_seg, m_lane;

  function automatic logic [7:0] lanes_of(input logic [7:0] seg, input logic [1:0] mode);
    logic [7:0] r;
    int n;
    int stride;
    r = '0;
    n = 1 << mode;
    stride = 8 / n;
    for (int j = 0; j < n; j++) r[j] = seg[(j+1)*stride-1];
    return r;
  endfunction

  task automatic model_step();
    if (!reset_n) begin
      m_busy = 0; m_hold = 0; m_n = 0; m_len = 0; m_mode = 0;
      m_s = 0; m_p = 0; m_c = 0; m_seg = 0; m_lane = 0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      if (!m_busy) begin
        m_mode = USE_SIMD;
        m_len  = (acc_len == 0) ? 1 : int'(acc_len);
        m_n    = 0;
        m_seg  = 0;
      end
      m_n++;
      m_s = S;
      m_c = simd_carry_out;
      for (int i = 0; i < 8; i++) m_seg[i] = m_seg[i] | simd_carry_out[2*i] | simd_carry_out[2*i+1];
      if (m_n == m_len) begin
        m_p    = S;
        m_lane = lanes_of(m_seg, m_mode);
        m_hold = 1;
        m_busy = 0;
      end else begin
        m_busy = 1;
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) model_step();

  always @(negedge clk) begin
    if (reset_n) begin
      check("in_ready",  64'(in_ready),      64'(!m_hold));
      check("out_valid", 64'(out_valid),     64'(m_hold));
      check("W_fb",      64'(W_fb),          m_busy ? 64'(m_s) : 64'(0));
      check("carry_fb",  64'(simd_carry_fb), m_busy ? 64'(m_c) : 64'(0));
      check("P",         64'(P),             64'(m_p));
      check("lane_flag", 64'(lane_flag),     64'(m_lane));
    end
  end

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] r64;
    logic [44:0] last_s;

    reset_n = 0; USE_SIMD = 0; acc_len = 0; in_valid = 0;
    S = 0; simd_carry_out = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    #1;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready",  64'(in_ready),  1);
    check("rst_P",         64'(P),         0);

    // 27x18, three beats
    @(posedge clk); #1;
    USE_SIMD = 2'b00; acc_len = 3; in_valid = 1; S = 45'd5;
    #1 check("t1_w0", 64'(W_fb), 0);
    @(posedge clk); #1 S = 45'd9;
    #1 check("t1_w1", 64'(W_fb), 5);
    @(posedge clk); #1 S = 45'd12;
    #1 check("t1_w2", 64'(W_fb), 9);
    check("t1_not_valid_yet", 64'(out_valid), 0);
    @(posedge clk); #1 in_valid = 0;
    check("t1_valid", 64'(out_valid), 1);
    check("t1_P",     64'(P), 12);
    check("t1_lane",  64'(lane_flag), 0);
    release_result();
    check("t1_released", 64'(out_valid), 0);

    // sum_4x4, carries seg1 then seg7
    @(posedge clk); #1;
    USE_SIMD = 2'b10; acc_len = 2; in_valid = 1; S = 45'd100; simd_carry_out = 16'h0004;
    @(posedge clk); #1 S = 45'd200; simd_carry_out = 16'h4000;
    #1 check("t2_cfb", 64'(simd_carry_fb), 64'h0004);
    @(posedge clk); #1 in_valid = 0; simd_carry_out = 0;
    check("t2_lane", 64'(lane_flag), 64'h09);
    check("t2_P",    64'(P), 200);
    release_result();

    // acc_len = 0 behaves as a single beat
    @(posedge clk); #1;
    USE_SIMD = 2'b11; acc_len = 0; in_valid = 1; S = 45'h1F;
    #1 check("t3_w0", 64'(W_fb), 0);
    @(posedge clk); #1 in_valid = 0;
    check("t3_valid", 64'(out_valid), 1);
    check("t3_P",     64'(P), 64'h1F);
    release_result();

    // backpressure in HOLD, then back-to-back restart
    @(posedge clk); #1;
    acc_len = 1; in_valid = 1; S = 45'h123;
    @(posedge clk); #1 S = 45'h456;
    for (int i = 0; i < 5; i++) begin
      check("t4_in_ready_hold", 64'(in_ready), 0);
      check("t4_P_stable",      64'(P), 64'h123);
      @(posedge clk); #1;
    end
    out_ready = 1; S = 45'h77;
    @(posedge clk); #1 out_ready = 0;
    check("t4_idle_valid", 64'(out_valid), 0);
    check("t4_idle_ready", 64'(in_ready), 1);
    @(posedge clk); #1 in_valid = 0;
    check("t4_restart_valid", 64'(out_valid), 1);
    check("t4_restart_P",     64'(P), 64'h77);
    release_result();

    // mode and length changes during ACC are ignored
    @(posedge clk); #1;
    USE_SIMD = 2'b01; acc_len = 3; in_valid = 1; S = 45'd1; simd_carry_out = 16'h4000;
    @(posedge clk); #1 USE_SIMD = 2'b11; acc_len = 1; S = 45'd2; simd_carry_out = 16'h0040;
    @(posedge clk); #1 S = 45'd3; simd_carry_out = 16'h0001;
    @(posedge clk); #1 in_valid = 0; simd_carry_out = 0;
    check("t5_valid", 64'(out_valid), 1);
    check("t5_lane",  64'(lane_flag), 64'h03);
    check("t5_P",     64'(P), 3);
    release_result();

    // asynchronous reset mid-accumulation
    @(posedge clk); #1;
    USE_SIMD = 2'b00; acc_len = 4; in_valid = 1; S = 45'd10;
    @(posedge clk); #1 S = 45'd20;
    @(posedge clk); #1 in_valid = 0;
    #2 reset_n = 0;
    #1;
    check("t6_rst_valid", 64'(out_valid),     0);
    check("t6_rst_ready", 64'(in_ready),      1);
    check("t6_rst_P",     64'(P),             0);
    check("t6_rst_lane",  64'(lane_flag),     0);
    check("t6_rst_W",     64'(W_fb),          0);
    check("t6_rst_cfb",   64'(simd_carry_fb), 0);
    @(posedge clk); #1 reset_n = 1;
    @(posedge clk); #1;
    acc_len = 1; in_valid = 1; S = 45'hABC;
    #1 check("t6_w0", 64'(W_fb), 0);
    @(posedge clk); #1 in_valid = 0;
    check("t6_valid", 64'(out_valid), 1);
    check("t6_P",     64'(P), 64'hABC);
    release_result();

    // maximum length, no counter wrap
    @(posedge clk); #1;
    USE_SIMD = 2'($urandom); acc_len = 8'd255; in_valid = 1;
    last_s = '0;
    for (int i = 0; i < 255; i++) begin
      r64 = {$urandom, $urandom};
      S = r64[44:0];
      last_s = r64[44:0];
      simd_carry_out = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if (i < 254) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1 in_valid = 0;
    check("t7_len255_valid", 64'(out_valid), 1);
    check("t7_len255_P",     64'(P), 64'(last_s));
    release_result();

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      r64 = {$urandom, $urandom};
      S = r64[44:0];
      simd_carry_out = 16'($urandom) & 16'($urandom) & 16'($urandom);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      USE_SIMD  = 2'($urandom);
      acc_len   = 8'($urandom_range(0, 6));
    end
    in_valid = 0; out_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
